// File: rtl/trace_pkg.sv
// trace_pkg -- shared types and constants for the trace drain block.
//   drain_state_t   : drain FSM state encoding
//   TRACE_HDR_MAGIC : upper half of the optional header word
//   hdr_word()      : builds the header word {magic, depth}
// The header word is only used when TRACE_DRAIN_HDR_EN is defined.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    PC    = 3'd2,
    INSTR = 3'd3,
    DONE  = 3'd4
  } drain_state_t;

  localparam logic [15:0] TRACE_HDR_MAGIC = 16'h7B0F;

  function automatic logic [31:0] hdr_word(input int depth);
    return {TRACE_HDR_MAGIC, 16'(depth)};
  endfunction

endpackage

// File: rtl/trace_stream_reg.sv
// trace_stream_reg -- single-entry registered stream output stage.
//   clk, rst      : clock, async active-high reset
//   load          : capture data/last and raise tvalid
//   clr           : drop the held word (abort)
//   data, last    : word to capture
//   ready         : downstream tready
//   tdata, tvalid, tlast : registered stream outputs
//   free          : a new word may be loaded on this edge
// A held word stays untouched until it is accepted, so tdata/tlast are
// stable across any number of stall cycles.
module trace_stream_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] data,
  input  logic        last,
  input  logic        ready,
  output logic [31:0] tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        free
);

  // Slot is free when empty or when the held word leaves on this edge.
  assign free = !tvalid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (clr) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tdata  <= data;
      tlast  <= last;
      tvalid <= 1'b1;
    end else if (tvalid && ready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/trace_drain.sv
// trace_drain -- drains a frozen trace buffer onto a valid/ready stream.
//   clk_i, rst_i          : clock, async active-high reset
//   start_i, abort_i      : begin / cancel a drain
//   triggered_i           : buffer frozen; a start is only accepted when set
//   wr_ptr_i              : oldest entry; the drain starts here
//   rd_addr_o             : buffer read address
//   rd_pc_i, rd_instr_i   : combinational buffer read data
//   tdata_o/tvalid_o/tready_i/tlast_o : output stream
//   busy_o, done_o, err_o : status (err_o is sticky until the next accepted start)
// Each entry is sent as a PC word then an INSTR word, DEPTH entries oldest
// first. Define TRACE_DRAIN_HDR_EN to prepend a {magic, DEPTH} header word.
module trace_drain
  import trace_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          triggered_i,
  input  logic [AW-1:0] wr_ptr_i,
  output logic [AW-1:0] rd_addr_o,
  input  logic [31:0]   rd_pc_i,
  input  logic [31:0]   rd_instr_i,
  output logic [31:0]   tdata_o,
  output logic          tvalid_o,
  input  logic          tready_i,
  output logic          tlast_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  drain_state_t  state;
  logic [CW-1:0] cnt;     // INSTR words loaded so far in this drain
  logic          load;
  logic          clr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          free;
  logic          xfer;

  assign xfer = tvalid_o && tready_i;

  // Decide which word (if any) enters the stream register this edge.
  always_comb begin
    load    = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    clr     = abort_i && (state != IDLE);
    if (!clr) begin
      case (state)
`ifdef TRACE_DRAIN_HDR_EN
        HDR: begin
          load    = free;
          ld_data = hdr_word(DEPTH);
        end
`endif
        PC: begin
          load    = free;
          ld_data = rd_pc_i;
        end
        INSTR: begin
          // Once every entry is loaded, just wait for the tlast word to go.
          load    = free && (cnt != FULL_CNT);
          ld_data = rd_instr_i;
          ld_last = (cnt == LAST_CNT);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rd_addr_o <= '0;
      cnt       <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else if (state == IDLE) begin
      done_o <= 1'b0;
      if (start_i) begin
        if (triggered_i) begin
          rd_addr_o <= wr_ptr_i;
          cnt       <= '0;
          err_o     <= 1'b0;
          busy_o    <= 1'b1;
`ifdef TRACE_DRAIN_HDR_EN
          state     <= HDR;
`else
          state     <= PC;
`endif
        end else begin
          err_o <= 1'b1;
        end
      end
    end else if (abort_i) begin
      // Abort wins over any transfer on the same edge.
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
`ifdef TRACE_DRAIN_HDR_EN
        HDR: if (load) state <= PC;
`endif
        PC: if (load) state <= INSTR;
        INSTR: begin
          if (load) begin
            cnt       <= cnt + 1'b1;
            rd_addr_o <= rd_addr_o + 1'b1;
            if (cnt != LAST_CNT) state <= PC;
          end else if (xfer && tlast_o) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  trace_stream_reg u_stream (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (load),
    .clr    (clr),
    .data   (ld_data),
    .last   (ld_last),
    .ready  (tready_i),
    .tdata  (tdata_o),
    .tvalid (tvalid_o),
    .tlast  (tlast_o),
    .free   (free)
  );

endmodule

// File: tb/tb_trace_drain.sv
// tb_trace_drain -- self-checking bench for trace_drain (DEPTH=4).
// The buffer is modelled as two arrays read combinationally; the expected
// word stream is built from the drain rules (optional header, then PC/INSTR
// pairs from wr_ptr upward, wrapping).
module tb_trace_drain;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          triggered;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_instr;
  logic [31:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          busy;
  logic          done;
  logic          err;

  logic [31:0] pc_mem [DEPTH];
  logic [31:0] in_mem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd_pc    = pc_mem[rd_addr];
  assign rd_instr = in_mem[rd_addr];

  trace_drain #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .triggered_i (triggered),
    .wr_ptr_i    (wr_ptr),
    .rd_addr_o   (rd_addr),
    .rd_pc_i     (rd_pc),
    .rd_instr_i  (rd_instr),
    .tdata_o     (tdata),
    .tvalid_o    (tvalid),
    .tready_i    (tready),
    .tlast_o     (tlast),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) begin
      pc_mem[i] = $urandom();
      in_mem[i] = $urandom();
    end
  endtask

  // mode 0: tready=1, mode 1: random tready + triggered drop,
  // mode 2: tready 1-0-0-1 mid-drain. abort_word<0 disables abort.
  task automatic drain(input int wp, input int mode, input int abort_word);
    logic [31:0] exp_q[$];
    logic [31:0] hold_d;
    logic        hold_l;
    logic        stalled;
    logic        rdy;
    int          idx;
    int          cyc;
    int          n;
    int          a;
    exp_q = {};
`ifdef TRACE_DRAIN_HDR_EN
    exp_q.push_back({16'h7B0F, 16'(DEPTH)});
`endif
    for (int k = 0; k < DEPTH; k++) begin
      a = (wp + k) % DEPTH;
      exp_q.push_back(pc_mem[a]);
      exp_q.push_back(in_mem[a]);
    end
    n = exp_q.size();

    wr_ptr = AW'(wp); triggered = 1'b1; start = 1'b1; tready = 1'b1;
    step();
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_tvalid", 32'(tvalid), 32'd0);
    check("accept_err", 32'(err), 32'd0);
    check("accept_addr", 32'(rd_addr), 32'(wp));
    if (mode == 1) triggered = 1'b0;
    step();
    check("first_tvalid", 32'(tvalid), 32'd1);

    idx = 0; cyc = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (idx < n && cyc < 200) begin
      if (stalled) begin
        check("stall_tvalid", 32'(tvalid), 32'd1);
        check("stall_tdata", tdata, hold_d);
        check("stall_tlast", 32'(tlast), 32'(hold_l));
      end
      if (mode == 2)      rdy = !(cyc == 3 || cyc == 4);
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else                rdy = 1'b1;
      tready = rdy;
      if (idx == abort_word && tvalid) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tvalid", 32'(tvalid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) begin
          step();
          check("abort_no_done", 32'(done), 32'd0);
          check("abort_idle_tvalid", 32'(tvalid), 32'd0);
        end
        return;
      end
      if (tvalid && rdy) begin
        check("word_data", tdata, exp_q[idx]);
        check("word_last", 32'(tlast), 32'(idx == n - 1));
        idx++;
      end
      stalled = tvalid && !rdy;
      hold_d  = tdata;
      hold_l  = tlast;
      step();
      cyc++;
    end
    check("word_count", 32'(idx), 32'(n));
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_tvalid", 32'(tvalid), 32'd0);
    step();
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("end_addr", 32'(rd_addr), 32'(wp));
    triggered = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; triggered = 1'b0;
    wr_ptr = '0; tready = 1'b0;
    fill_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Start while not triggered: rejected, sticky error.
    triggered = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("rej_err", 32'(err), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    repeat (3) begin
      check("rej_tvalid", 32'(tvalid), 32'd0);
      check("rej_err_sticky", 32'(err), 32'd1);
      step();
    end

    drain(2, 0, -1);   // basic drain with wrap 2,3,0,1
    drain(2, 2, -1);   // stall mid-drain
    drain(1, 0, 2);    // abort on the 3rd word
    for (int i = 0; i < 4; i++) begin
      fill_mem();
      drain(int'($urandom_range(0, DEPTH - 1)), 1, -1);
    end

    // Reset mid-drain: outputs clear without waiting for a clock edge.
    wr_ptr = AW'(3); triggered = 1'b1; start = 1'b1; tready = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("arst_addr", 32'(rd_addr), 32'd0);
    check("arst_tdata", tdata, 32'd0);
    check("arst_tvalid", 32'(tvalid), 32'd0);
    check("arst_tlast", 32'(tlast), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    fill_mem();
    drain(0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_drain.md
TRACE_DRAIN -- requirements
Module: trace_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of trace-buffer entries (power of two, at least 2).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: single-cycle request to begin a drain.
REQ-005 SHALL have port abort_i, input, 1 bit: cancels a drain in progress.
REQ-006 SHALL have port triggered_i, input, 1 bit: the trace buffer is frozen.
REQ-007 SHALL have port wr_ptr_i, input, $clog2(DEPTH) bits: the buffer's next write slot, which is the oldest entry.
REQ-008 SHALL have port rd_addr_o, output, $clog2(DEPTH) bits: read address driven to the buffer.
REQ-009 SHALL have ports rd_pc_i and rd_instr_i, input, 32 bits each: combinational read data for rd_addr_o.
REQ-010 SHALL have port tdata_o, output, 32 bits: stream data word.
REQ-011 SHALL have ports tvalid_o (output, 1 bit), tready_i (input, 1 bit) and tlast_o (output, 1 bit): stream handshake and last-word marker.
REQ-012 SHALL have port busy_o, output, 1 bit: a drain is active.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port err_o, output, 1 bit: sticky flag for a rejected start.

Function
REQ-015 SHALL implement the FSM states IDLE, HDR, PC, INSTR, DONE.
REQ-016 SHALL, in IDLE, accept start_i only when triggered_i=1, latch rd_addr_o<=wr_ptr_i, clear the entry counter, and move to HDR (macro defined) or PC (macro undefined).
REQ-017 SHALL, when start_i=1 arrives with triggered_i=0 in IDLE, stay in IDLE and set err_o; err_o clears only on the next accepted start.
REQ-018 SHALL ignore start_i while busy_o=1.
REQ-019 SHALL register tdata_o, tvalid_o and tlast_o; the first tvalid_o rises exactly one cycle after the accepting start_i edge.
REQ-020 SHALL consider a word transferred only on a cycle where tvalid_o=1 and tready_i=1; while tvalid_o=1 and tready_i=0, tdata_o and tlast_o hold stable.
REQ-021 SHALL sequence one entry as a PC word (rd_pc_i) then an INSTR word (rd_instr_i); after the INSTR transfer, rd_addr_o increments modulo DEPTH (DEPTH-1 wraps to 0).
REQ-022 SHALL emit exactly DEPTH entries (2*DEPTH data words) per drain, oldest first.
REQ-023 SHALL drive tlast_o=1 only on the final INSTR word.
REQ-024 SHALL, after the tlast_o transfer, enter DONE for one cycle with done_o=1, then return to IDLE.
REQ-025 SHALL keep busy_o=1 in every state except IDLE.
REQ-026 SHALL, on abort_i=1 in any non-IDLE state, return to IDLE on the next edge with tvalid_o=0 and no done_o pulse; abort_i takes priority over a simultaneous transfer.
REQ-027 SHALL let a triggered_i fall during a drain have no effect on the drain.
REQ-028 SHALL use an entry counter of $clog2(DEPTH)+1 bits so that DEPTH itself is representable.

Reset
REQ-029 SHALL, on rst_i=1, immediately force IDLE with rd_addr_o=0, tdata_o=0, tvalid_o=0, tlast_o=0, busy_o=0, done_o=0, err_o=0.
REQ-030 SHALL, on reset mid-drain, drop the drain with no done_o pulse.

Configuration
REQ-031 SHALL use macro TRACE_DRAIN_HDR_EN: when defined, one header word {TRACE_HDR_MAGIC[15:0], 16'(DEPTH)} precedes the entries, giving 2*DEPTH+1 words per drain.
REQ-032 SHALL, with TRACE_DRAIN_HDR_EN undefined, omit the HDR state entirely, so the PC word of the oldest entry is the first word.

Structure
REQ-033 SHALL take the state enum type and TRACE_HDR_MAGIC = 16'h7B0F from a shared package, trace_pkg.
REQ-034 SHALL place the output register plus valid/ready hold logic in one sub-module, trace_stream_reg; the FSM and address counter stay in trace_drain.

Verification
REQ-035 SHALL cover: DEPTH=4, wr_ptr_i=2, triggered_i=1, start_i pulse, tready_i=1 -> rd_addr sequence 2,3,0,1; 8 words (9 with header); tlast_o on word 8; done_o one cycle later.
REQ-036 SHALL cover: start_i with triggered_i=0 -> err_o=1, busy_o=0, tvalid_o never asserted.
REQ-037 SHALL cover: tready_i toggling 1-0-0-1 mid-drain -> tdata_o stable while stalled, no word lost or duplicated.
REQ-038 SHALL cover: abort_i asserted on the 3rd word -> IDLE next cycle, tvalid_o=0, no done_o pulse.
REQ-039 SHALL cover: with TRACE_DRAIN_HDR_EN defined and DEPTH=64 -> first word 32'h7B0F0040.
REQ-040 SHALL cover: rst_i pulse mid-drain -> all outputs 0 asynchronously; a new start_i after reset drains normally.
